mskaes_128bits_round_ctrl: RTL and testbench

//  Sequencer for the masked AES-128 round datapath: state/key register enables, round counter,

---
 rtl/mskaes_128bits_round_ctrl_pkg.sv | 23 ++
 rtl/mskaes_128bits_round_ctrl_rcon_step.sv | 16 +
 rtl/mskaes_128bits_round_ctrl.sv | 138 +++++++++++++
 tb/tb_mskaes_128bits_round_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared constants, state encoding and GF(2^8) helper for the masked AES-128 round sequencer.
// No logic of its own; latency not applicable.
// No flow control; pure definitions.
package mskaes_128bits_round_ctrl_pkg;

   // Controller phases: wait for a block, run the rounds, present the result, flush the pipelines
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_CLEAN = 2'd3
   } ctrl_state_e;

   localparam int          NROUNDS    = 10;
   localparam logic [3:0]  ROUND_LAST = 4'(NROUNDS);
   localparam logic [7:0]  RCON_INIT  = 8'h01;

   // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/mskaes_128bits_round_ctrl_rcon_step.sv
// Next round constant from the current one (GF(2^8) xtime, 8'h80 wraps to 8'h1b).
// Purely combinational, zero cycles.
// No flow control.
module mskaes_rcon_step
   import mskaes_128bits_round_ctrl_pkg::*;
(
   input  logic [7:0] rcon_in,
   output logic [7:0] rcon_out
);

   // Single GF(2^8) doubling; kept as a module so key-schedule tests can reuse it
   always_comb begin
      rcon_out = gf_xtime(rcon_in);
   end

endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Sequencer for the masked AES-128 round datapath: enables, round counter, RCON, MC bypass, cleaning.
// One block takes 10*LATENCY cycles after acceptance; out_valid follows one cycle after the last update.
// Result held in FINAL until out_ready; new blocks accepted only in IDLE (in_ready).
module mskaes_128bits_round_ctrl
   import mskaes_128bits_round_ctrl_pkg::*;
#(
   parameter int LATENCY      = 4,
   parameter int CLEAN_CYCLES = LATENCY
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       en_load,
   output logic       en_state,
   output logic       en_key,
   output logic       sel_last,
   output logic [7:0] rcon,
   output logic [3:0] round_idx,
   output logic       cleaning_on,
   output logic       rnd_req
);

   localparam int LW = $clog2(LATENCY + 1);
   localparam int CW = $clog2(CLEAN_CYCLES + 1);
   localparam logic [LW-1:0] LAT_LAST   = LW'(LATENCY - 1);
   localparam logic [CW-1:0] CLEAN_LAST = CW'(CLEAN_CYCLES - 1);

   ctrl_state_e   state, state_nxt;
   logic [LW-1:0] lat_cnt, lat_cnt_nxt;
   logic [CW-1:0] clean_cnt, clean_cnt_nxt;
   logic [3:0]    round_nxt;
   logic [7:0]    rcon_nxt;
   logic [7:0]    rcon_step;

   mskaes_rcon_step u_rcon_step (
      .rcon_in  (rcon),
      .rcon_out (rcon_step)
   );

   // State, counters, round index and round constant; reset abandons any block in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         lat_cnt   <= '0;
         clean_cnt <= '0;
         round_idx <= 4'd0;
         rcon      <= RCON_INIT;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_cnt_nxt;
         clean_cnt <= clean_cnt_nxt;
         round_idx <= round_nxt;
         rcon      <= rcon_nxt;
      end
   end

   // Next-state and output decode; only en_load looks at an input combinationally
   always_comb begin
      state_nxt     = state;
      lat_cnt_nxt   = lat_cnt;
      clean_cnt_nxt = clean_cnt;
      round_nxt     = round_idx;
      rcon_nxt      = rcon;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      busy          = 1'b0;
      en_load       = 1'b0;
      en_state      = 1'b0;
      en_key        = 1'b0;
      sel_last      = 1'b0;
      cleaning_on   = 1'b0;
      rnd_req       = 1'b0;

      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               en_load     = 1'b1;
               state_nxt   = ST_ROUND;
               lat_cnt_nxt = '0;
               round_nxt   = 4'd1;
            end
         end

         ST_ROUND: begin
            busy     = 1'b1;
            rnd_req  = 1'b1;
            sel_last = (round_idx == ROUND_LAST);
            if (lat_cnt == LAT_LAST) begin
               // Round output leaves the S-box pipeline this cycle
               en_state    = 1'b1;
               en_key      = 1'b1;
               lat_cnt_nxt = '0;
               if (round_idx == ROUND_LAST) begin
                  // Round index and RCON stay on round 10 until the pipeline is cleaned
                  state_nxt = ST_FINAL;
               end else begin
                  round_nxt = round_idx + 4'd1;
                  rcon_nxt  = rcon_step;
               end
            end else begin
               lat_cnt_nxt = lat_cnt + LW'(1);
            end
         end

         ST_FINAL: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt     = ST_CLEAN;
               clean_cnt_nxt = '0;
            end
         end

         ST_CLEAN: begin
            busy        = 1'b1;
            cleaning_on = 1'b1;
            rnd_req     = 1'b1;
            if (clean_cnt == CLEAN_LAST) begin
               state_nxt = ST_IDLE;
               rcon_nxt  = RCON_INIT;
               round_nxt = 4'd0;
            end else begin
               clean_cnt_nxt = clean_cnt + CW'(1);
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Bench for the masked AES-128 round sequencer at LATENCY 4, 1 and 6 (CLEAN_CYCLES = LATENCY).
// A cycle-level model per instance is compared on every negative edge; directed checks pin it.
// Stimulus drives in_valid/out_ready/rst one time step after the rising edge.
module tb_mskaes_128bits_round_ctrl;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a       [NI];
   logic       in_valid_a  [NI];
   logic       out_ready_a [NI];
   logic       in_ready_w  [NI];
   logic       out_valid_w [NI];
   logic       busy_w      [NI];
   logic       en_load_w   [NI];
   logic       en_state_w  [NI];
   logic       en_key_w    [NI];
   logic       sel_last_w  [NI];
   logic       cleaning_w  [NI];
   logic       rnd_req_w   [NI];
   logic [7:0] rcon_w      [NI];
   logic [3:0] round_w     [NI];

   int checks = 0;
   int errors = 0;

   function automatic int lat_of(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 6);
   endfunction

   function automatic logic [7:0] rcon_of(input int r);
      case (r)
         1:  return 8'h01;
         2:  return 8'h02;
         3:  return 8'h04;
         4:  return 8'h08;
         5:  return 8'h10;
         6:  return 8'h20;
         7:  return 8'h40;
         8:  return 8'h80;
         9:  return 8'h1b;
         10: return 8'h36;
         default: return 8'h01;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LG = (g == 0) ? 4 : ((g == 1) ? 1 : 6);
      mskaes_128bits_round_ctrl #(.LATENCY(LG), .CLEAN_CYCLES(LG)) u_dut (
         .clk         (clk),
         .rst         (rst_a[g]),
         .in_valid    (in_valid_a[g]),
         .in_ready    (in_ready_w[g]),
         .out_valid   (out_valid_w[g]),
         .out_ready   (out_ready_a[g]),
         .busy        (busy_w[g]),
         .en_load     (en_load_w[g]),
         .en_state    (en_state_w[g]),
         .en_key      (en_key_w[g]),
         .sel_last    (sel_last_w[g]),
         .rcon        (rcon_w[g]),
         .round_idx   (round_w[g]),
         .cleaning_on (cleaning_w[g]),
         .rnd_req     (rnd_req_w[g])
      );
   end

   // Model: phase 0 idle, 1 running (k = cycles since acceptance), 2 result held, 3 cleaning
   int m_mode [NI];
   int m_k    [NI];
   int m_cc   [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_mode[i] = 0;
         m_k[i]    = 0;
         m_cc[i]   = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int L;
         int r;
         logic e_ir, e_ov, e_busy, e_ld, e_es, e_sl, e_cl, e_rr;
         logic [7:0] e_rcon;
         logic [3:0] e_rnd;
         logic [20:0] ev, av;
         L = lat_of(i);
         r = 0;
         e_ir = 1'b0; e_ov = 1'b0; e_busy = 1'b0; e_ld = 1'b0;
         e_es = 1'b0; e_sl = 1'b0; e_cl = 1'b0; e_rr = 1'b0;
         e_rcon = 8'h01; e_rnd = 4'd0;
         case (m_mode[i])
            0: begin
               e_ir = 1'b1;
               e_ld = in_valid_a[i];
            end
            1: begin
               r      = (m_k[i] - 1) / L + 1;
               e_busy = 1'b1;
               e_rr   = 1'b1;
               e_es   = (m_k[i] % L == 0);
               e_sl   = (r == 10);
               e_rcon = rcon_of(r);
               e_rnd  = 4'(r);
            end
            2: begin
               e_busy = 1'b1;
               e_ov   = 1'b1;
               e_rcon = 8'h36;
               e_rnd  = 4'd10;
            end
            default: begin
               e_busy = 1'b1;
               e_cl   = 1'b1;
               e_rr   = 1'b1;
               e_rcon = 8'h36;
               e_rnd  = 4'd10;
            end
         endcase
         ev = {e_ir, e_ov, e_busy, e_ld, e_es, e_es, e_sl, e_rcon, e_rnd, e_cl, e_rr};
         av = {in_ready_w[i], out_valid_w[i], busy_w[i], en_load_w[i], en_state_w[i],
               en_key_w[i], sel_last_w[i], rcon_w[i], round_w[i], cleaning_w[i], rnd_req_w[i]};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL model_cycle dut%0d t=%0t: got %h, expected %h", i, $time, av, ev);
         end
         // Advance the model by the rising edge that follows
         if (rst_a[i]) begin
            m_mode[i] = 0;
         end else begin
            case (m_mode[i])
               0: if (in_valid_a[i]) begin m_mode[i] = 1; m_k[i] = 1; end
               1: if (m_k[i] == 10 * L) m_mode[i] = 2; else m_k[i] = m_k[i] + 1;
               2: if (out_ready_a[i]) begin m_mode[i] = 3; m_cc[i] = 1; end
               default: if (m_cc[i] == L) m_mode[i] = 0; else m_cc[i] = m_cc[i] + 1;
            endcase
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for the result, hold it for 'hold' cycles, hand it off, then wait for IDLE
   task automatic finish_block(input int i, input int hold);
      int n;
      bit seen;
      n = 0; seen = 1'b0;
      while (n < 200 && !seen) begin
         @(negedge clk);
         if (out_valid_w[i]) seen = 1'b1;
         tick();
         n++;
      end
      chk("out_valid_seen", int'(seen), 1);
      repeat (hold) tick();
      out_ready_a[i] = 1'b1;
      tick();
      out_ready_a[i] = 1'b0;
      n = 0; seen = 1'b0;
      while (n < 200 && !seen) begin
         @(negedge clk);
         if (in_ready_w[i]) seen = 1'b1;
         tick();
         n++;
      end
      chk("idle_seen", int'(seen), 1);
   endtask

   // in_valid and out_ready held high: blocks run back to back, accepted only from IDLE
   task automatic scn_held(input int i);
      int per;
      int loads;
      int n;
      bit seen;
      per   = 11 * lat_of(i) + 2;
      loads = 0;
      out_ready_a[i] = 1'b1;
      in_valid_a[i]  = 1'b1;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (en_load_w[i]) loads++;
         tick();
      end
      in_valid_a[i] = 1'b0;
      chk("held_loads", loads, (150 + per - 1) / per);
      n = 0; seen = 1'b0;
      while (n < 200 && !seen) begin
         @(negedge clk);
         if (in_ready_w[i]) seen = 1'b1;
         tick();
         n++;
      end
      out_ready_a[i] = 1'b0;
      chk("held_idle_seen", int'(seen), 1);
   endtask

   task automatic scn0();
      int offs[$];
      int rcs[$];
      int sls[$];
      int first_ov;
      int cl_cnt;
      logic [7:0] exp_rcon [10];
      exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      first_ov = -1;
      // Block 1: pulse timing, RCON per pulse, result held for 8 cycles
      tick();
      in_valid_a[0] = 1'b1;
      for (int off = 0; off <= 48; off++) begin
         @(negedge clk);
         if (en_key_w[0]) begin
            offs.push_back(off);
            rcs.push_back(int'(rcon_w[0]));
            sls.push_back(int'(sel_last_w[0]));
         end
         if (out_valid_w[0] && first_ov < 0) first_ov = off;
         tick();
         in_valid_a[0] = 1'b0;
      end
      chk("pulse_count", offs.size(), 10);
      for (int j = 0; j < 10 && j < offs.size(); j++) begin
         chk("pulse_cycle", offs[j], 4 * (j + 1));
         chk("pulse_rcon", rcs[j], int'(exp_rcon[j]));
         chk("pulse_sel_last", sls[j], (j == 9) ? 1 : 0);
      end
      chk("first_out_valid", first_ov, 41);
      out_ready_a[0] = 1'b1;
      tick();
      out_ready_a[0] = 1'b0;
      cl_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (cleaning_w[0]) cl_cnt++;
         tick();
      end
      chk("clean_len", cl_cnt, 4);
      @(negedge clk);
      chk("post_clean_in_ready", int'(in_ready_w[0]), 1);
      chk("post_clean_rcon", int'(rcon_w[0]), 1);
      chk("post_clean_round", int'(round_w[0]), 0);
      tick();
      // Block 2: reset during round 5, lat_cnt 2, then a fresh block
      in_valid_a[0] = 1'b1;
      tick();
      in_valid_a[0] = 1'b0;
      repeat (18) tick();
      rst_a[0] = 1'b1;
      tick();
      rst_a[0] = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready_w[0]), 1);
      chk("rst_busy", int'(busy_w[0]), 0);
      chk("rst_round", int'(round_w[0]), 0);
      chk("rst_rcon", int'(rcon_w[0]), 1);
      chk("rst_rnd_req", int'(rnd_req_w[0]), 0);
      tick();
      in_valid_a[0] = 1'b1;
      tick();
      in_valid_a[0] = 1'b0;
      @(negedge clk);
      chk("restart_round", int'(round_w[0]), 1);
      chk("restart_rcon", int'(rcon_w[0]), 1);
      tick();
      finish_block(0, 2);
      scn_held(0);
   endtask

   task automatic scn_other(input int i);
      tick();
      in_valid_a[i] = 1'b1;
      tick();
      in_valid_a[i] = 1'b0;
      finish_block(i, 3);
      scn_held(i);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst_a[i]       = 1'b1;
         in_valid_a[i]  = 1'b0;
         out_ready_a[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
      fork
         scn0();
         scn_other(1);
         scn_other(2);
      join
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL global_timeout: got t=%0t, expected completion earlier", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
